// File: rtl/ffdiv_pkg.sv
// Shared types and constants for the sequential GF(2^m) divider ffdiv_seq.
package ffdiv_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SQ   = 3'd1,
    MUL  = 3'd2,
    FIN  = 3'd3,
    DONE = 3'd4
  } ffdiv_state_e;

  // Plain vector encodings of the FSM states for the state register
  localparam logic [2:0] ST_IDLE = IDLE;
  localparam logic [2:0] ST_SQ   = SQ;
  localparam logic [2:0] ST_MUL  = MUL;
  localparam logic [2:0] ST_FIN  = FIN;
  localparam logic [2:0] ST_DONE = DONE;

  localparam int unsigned FFDIV_POLY_DEF = 32'h11d;

  function automatic int unsigned ffdiv_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Iteration counter width; never below one bit
  function automatic int unsigned ffdiv_cnt_w(input int unsigned grade);
    int unsigned w;
    w = ffdiv_clog2(grade);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/ffmul.sv
// Combinational GF(2^m) multiplier: MSB-first shift-and-add with interleaved reduction.
module ffmul #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned GRADE_W    = 5
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [GRADE_W-1:0]    polyn_grade,
  input  logic [DATA_WIDTH-1:0] polyn_red_in,
  output logic [DATA_WIDTH-1:0] p_o
);

  logic [DATA_WIDTH-1:0] acc_c;

  // Operands are reduced (< 2^m), so each shift can overflow into bit m only
  always_comb begin
    acc_c = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      acc_c = acc_c << 1;
      if (acc_c[polyn_grade]) acc_c = acc_c ^ polyn_red_in;
      if (b_i[i]) acc_c = acc_c ^ a_i;
    end
  end

  assign p_o = acc_c;

endmodule

// File: rtl/ffdiv_seq.sv
// Sequential GF(2^m) divider q = a * b^(2^m-2) using one shared ffmul (Itoh-Tsujii steps).
// Define FFDIV_DBZ_EN to short-circuit a zero divisor straight to DONE with out_dbz=1.
module ffdiv_seq
  import ffdiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned POLY_GRADE = 8,
  parameter int unsigned POLY_RED   = FFDIV_POLY_DEF
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_q,
  output logic                  out_dbz
);

  localparam int unsigned GW = ffdiv_clog2(DATA_WIDTH);
  localparam int unsigned CW = ffdiv_cnt_w(POLY_GRADE);
  localparam logic [DATA_WIDTH-1:0] OP_MASK = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - POLY_GRADE);
  localparam logic [CW-1:0] CNT_LAST = CW'(POLY_GRADE - 2);

  logic [2:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] ra_q, ra_d;
  logic [DATA_WIDTH-1:0] sq_q, sq_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] q_q, q_d;
  logic                  dbz_q, dbz_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;

  logic [DATA_WIDTH-1:0] mul_a_c, mul_b_c, mul_p_c;

  ffmul #(
    .DATA_WIDTH(DATA_WIDTH),
    .GRADE_W   (GW)
  ) u_ffmul (
    .a_i         (mul_a_c),
    .b_i         (mul_b_c),
    .polyn_grade (GW'(POLY_GRADE)),
    .polyn_red_in(DATA_WIDTH'(POLY_RED)),
    .p_o         (mul_p_c)
  );

  // Next-state, datapath and shared-multiplier operand selection
  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    sq_d    = sq_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    dbz_d   = dbz_q;
    mul_a_c = acc_q;
    mul_b_c = sq_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q && !flush) begin
          ra_d    = in_a & OP_MASK;
          sq_d    = in_b & OP_MASK;
          acc_d   = DATA_WIDTH'(1);
          cnt_d   = '0;
          dbz_d   = 1'b0;
          state_d = ST_SQ;
`ifdef FFDIV_DBZ_EN
          if ((in_b & OP_MASK) == '0) begin
            q_d     = '0;
            dbz_d   = 1'b1;
            state_d = ST_DONE;
          end
`endif
        end
      end
      ST_SQ: begin
        mul_a_c = sq_q;
        mul_b_c = sq_q;
        sq_d    = mul_p_c;
        state_d = ST_MUL;
      end
      // acc accumulates b^(2^1) * ... * b^(2^(m-1)) = b^(2^m-2)
      ST_MUL: begin
        mul_a_c = acc_q;
        mul_b_c = sq_q;
        acc_d   = mul_p_c;
        cnt_d   = cnt_q + CW'(1);
        state_d = (cnt_q == CNT_LAST) ? ST_FIN : ST_SQ;
      end
      ST_FIN: begin
        mul_a_c = acc_q;
        mul_b_c = ra_q;
        q_d     = mul_p_c;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) state_d = ST_IDLE;

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= ST_IDLE;
      ra_q        <= '0;
      sq_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      q_q         <= '0;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ra_q        <= ra_d;
      sq_q        <= sq_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      q_q         <= q_d;
      dbz_q       <= dbz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_q     = q_q;
  assign out_dbz   = dbz_q;

endmodule

// File: tb/tb_ffdiv_seq.sv
// Self-checking bench for ffdiv_seq (m=8, poly 0x11d): vector table, corner sequences, random and sweep.
module tb_ffdiv_seq;

  localparam logic [15:0] POLY = 16'h11d;
`ifdef FFDIV_DBZ_EN
  localparam int  LAT_ZERO = 1;
  localparam logic DBZ_ZERO = 1'b1;
`else
  localparam int  LAT_ZERO = 16;
  localparam logic DBZ_ZERO = 1'b0;
`endif
  localparam int LAT_NORM = 16;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_q;
  logic        out_dbz;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ffdiv_seq #(
    .DATA_WIDTH(32),
    .POLY_GRADE(8),
    .POLY_RED  (32'h11d)
  ) dut (
    .clk      (clk),
    .rst_l    (rst_l),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_q    (out_q),
    .out_dbz  (out_dbz)
  );

  // Reference: schoolbook carry-less product, then reduce from the top
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] prod;
    prod = '0;
    for (int i = 0; i < 8; i++) if (y[i]) prod = prod ^ (16'(x) << i);
    for (int k = 15; k >= 8; k--) if (prod[k]) prod = prod ^ (POLY << (k - 8));
    return prod[7:0];
  endfunction

  // Reference division by definition: the unique q with q*b == a
  function automatic logic [7:0] gdiv(input logic [7:0] a, input logic [7:0] b);
    if (b == 8'd0) return 8'd0;
    for (int q = 0; q < 256; q++) if (gmul(8'(q), b) == a) return 8'(q);
    return 8'd0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One full transaction; lat counts edges from the accepting edge (=1) to out_valid high
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic dbz, output int lat);
    @(negedge clk);
    in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    q = out_q; dbz = out_dbz;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q, expq;
    logic        dbz;
    int          lat, seen;
    logic [31:0] ra, rb;

    vecs[0] = '{32'h1,          32'h2,          32'h8e, 1'b0,     LAT_NORM};
    vecs[1] = '{32'h4,          32'h2,          32'h02, 1'b0,     LAT_NORM};
    vecs[2] = '{32'h53,         32'h53,         32'h01, 1'b0,     LAT_NORM};
    vecs[3] = '{32'h0,          32'h5,          32'h00, 1'b0,     LAT_NORM};
    vecs[4] = '{32'h7,          32'h1,          32'h07, 1'b0,     LAT_NORM};
    vecs[5] = '{32'h1,          32'h3,          32'hf4, 1'b0,     LAT_NORM};
    vecs[6] = '{32'hffff_ff01,  32'habcd_0002,  32'h8e, 1'b0,     LAT_NORM};
    vecs[7] = '{32'h9,          32'h0,          32'h00, DBZ_ZERO, LAT_ZERO};
    vecs[8] = '{32'h3c,         32'h0000_0100,  32'h00, DBZ_ZERO, LAT_ZERO};

    // Reset values
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_q", out_q, 32'd0);
    check("rst_out_dbz", 32'(out_dbz), 32'd0);
    @(negedge clk);
    rst_l = 1'b1;
    repeat (2) @(posedge clk);

    // Directed vector table
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].a, vecs[i].b, q, dbz, lat);
      check($sformatf("vec%0d_q", i), q, vecs[i].q);
      check($sformatf("vec%0d_dbz", i), 32'(dbz), 32'(vecs[i].dbz));
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Consumer stall in DONE: result holds, in_valid pulses ignored
    @(negedge clk);
    in_a = 32'h53; in_b = 32'h7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    expq = 32'(gdiv(8'h53, 8'h7));
    check("stall_lat", 32'(lat), 32'(LAT_NORM));
    check("stall_q0", out_q, expq);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check($sformatf("stall_valid%0d", k), 32'(out_valid), 32'd1);
      check($sformatf("stall_q%0d", k), out_q, expq);
      check($sformatf("stall_ready%0d", k), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("stall_drop_valid", 32'(out_valid), 32'd0);
    check("stall_idle_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (20) begin @(posedge clk); #1; if (out_valid) seen++; end
    check("stall_no_ghost_op", 32'(seen), 32'd0);

    // Flush mid-op: no result, then a clean op follows
    @(negedge clk);
    in_a = 32'h5; in_b = 32'h9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (25) begin @(posedge clk); #1; if (out_valid) seen++; end
    check("flush_no_result", 32'(seen), 32'd0);
    run_op(32'h1, 32'h3, q, dbz, lat);
    check("postflush_q", q, 32'hf4);
    check("postflush_lat", 32'(lat), 32'(LAT_NORM));

    // Flush together with in_valid in IDLE blocks the accept
    @(negedge clk);
    in_a = 32'h1; in_b = 32'h2; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (20) begin @(posedge clk); #1; if (out_valid) seen++; end
    check("flush_idle_no_result", 32'(seen), 32'd0);

    // Async reset while holding a result in DONE
    @(negedge clk);
    in_a = 32'h1; in_b = 32'h2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    check("prerst_q", out_q, 32'h8e);
    #2 rst_l = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_q", out_q, 32'd0);
    check("arst_ready", 32'(in_ready), 32'd1);
    check("arst_dbz", 32'(out_dbz), 32'd0);
    @(negedge clk);
    rst_l = 1'b1;

    // Async reset mid-iteration aborts the op
    @(negedge clk);
    in_a = 32'h11; in_b = 32'h22; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_l = 1'b0;
    #1;
    check("arst_mid_ready", 32'(in_ready), 32'd1);
    check("arst_mid_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_l = 1'b1;
    seen = 0;
    repeat (25) begin @(posedge clk); #1; if (out_valid) seen++; end
    check("arst_mid_no_result", 32'(seen), 32'd0);

    // Random operands including junk upper bits
    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      rb = $urandom;
      if (n % 8 == 0) rb = rb & 32'hffff_ff00;
      run_op(ra, rb, q, dbz, lat);
      check($sformatf("rnd%0d_q", n), q, 32'(gdiv(ra[7:0], rb[7:0])));
      check($sformatf("rnd%0d_dbz", n), 32'(dbz), (rb[7:0] == 8'd0) ? 32'(DBZ_ZERO) : 32'd0);
      check($sformatf("rnd%0d_lat", n), 32'(lat), (rb[7:0] == 8'd0) ? 32'(LAT_ZERO) : 32'(LAT_NORM));
    end

    // Inverse sweep: b * (1/b) == 1 for every nonzero b
    for (int b = 1; b < 256; b++) begin
      run_op(32'h1, 32'(b), q, dbz, lat);
      check($sformatf("inv%0d", b), 32'(gmul(q[7:0], 8'(b))), 32'd1);
      check($sformatf("inv%0d_hi", b), q & 32'hffff_ff00, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
